// File: rtl/usb_tx.sv
// usb_tx: USB low-speed transmit serializer (SYNC, LSB-first data, bit stuffing, NRZI, EOP).
package types;
    typedef enum logic [1:0] {SE0 = 2'b00, J = 2'b01, K = 2'b10} d_port_t;
endpackage

module usb_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           reset,
    input  logic           clk,
    input  logic [7:0]     tx_data,
    input  logic           tx_valid,
    output logic           tx_ready,
    output types::d_port_t q,
    output logic           oe,
    output logic           busy
);
    import types::*;

    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [2:0]    ones, ones_n;
    logic [7:0]    sh, sh_n;
    d_port_t       q_n;
    logic          wrap, send, bit_val;

    assign wrap = timer == TW'(CLKS_PER_BIT - 1);
    assign busy = state != IDLE;
    assign oe   = busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            ones    <= '0;
            sh      <= '0;
            q       <= J;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_cnt <= bit_n;
            ones    <= ones_n;
            sh      <= sh_n;
            q       <= q_n;
        end
    end

    // SYNC is shifted out of sh like a data byte; bit_cnt is the index of the last data bit on the line
    always_comb begin
        state_n  = state;
        timer_n  = busy ? (wrap ? '0 : timer + 1'b1) : timer;
        bit_n    = bit_cnt;
        ones_n   = ones;
        sh_n     = sh;
        q_n      = q;
        tx_ready = 1'b0;
        send     = 1'b0;
        bit_val  = 1'b0;
        case (state)
            IDLE: if (tx_valid) begin
                state_n = SYNC;
                sh_n    = 8'h80;
                bit_n   = '0;
                ones_n  = '0;
                q_n     = K;
            end
            SYNC, DATA: if (wrap) begin
                if (ones == 3'd6) begin
                    send = 1'b1;
                end else if (bit_cnt != 3'd7) begin
                    bit_n   = bit_cnt + 1'b1;
                    sh_n    = sh >> 1;
                    send    = 1'b1;
                    bit_val = sh[1];
                end else if (tx_valid) begin
                    state_n  = DATA;
                    sh_n     = tx_data;
                    bit_n    = '0;
                    tx_ready = 1'b1;
                    send     = 1'b1;
                    bit_val  = tx_data[0];
                end else begin
                    state_n = EOP_SE0;
                    bit_n   = '0;
                    q_n     = SE0;
                end
            end
            EOP_SE0: if (wrap) begin
                if (bit_cnt == 3'd0) bit_n = 3'd1;
                else begin
                    state_n = EOP_J;
                    q_n     = J;
                end
            end
            EOP_J: if (wrap) state_n = IDLE;
            default: ;
        endcase
        if (send) begin
            q_n    = bit_val ? q : (q == J ? K : J);
            ones_n = bit_val ? ones + 1'b1 : 3'd0;
        end
    end
endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: directed packets against a scoreboard of expected line symbols and tx_ready timing.
module tb_usb_tx;
    import types::*;

    logic       reset, clk, tx_valid, tx_ready, oe, busy;
    logic [7:0] tx_data;
    d_port_t    q;

    usb_tx #(.CLKS_PER_BIT(16)) dut (
        .reset(reset), .clk(clk), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .q(q), .oe(oe), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    d_port_t exp_q[$];
    int rdy_exp[$], rdy_t[$];
    logic [7:0] pk[4];
    logic lvl;
    int ones_m, nsym, t_b, busy_len, pcyc = 0, cyc_g = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference encoder: NRZI level starts at J, stuff a 0 after six consecutive 1s
    task automatic emit(input logic b);
        if (!b) lvl = ~lvl;
        exp_q.push_back(lvl ? J : K);
        nsym++;
        ones_m = b ? ones_m + 1 : 0;
    endtask

    task automatic model(input int n);
        logic [7:0] b;
        lvl = 1'b1;
        ones_m = 0;
        nsym = 0;
        rdy_exp.delete();
        rdy_t.delete();
        for (int i = 0; i <= n; i++) begin
            b = (i == 0) ? 8'h80 : pk[i-1];
            if (i > 0) rdy_exp.push_back(nsym);
            for (int k = 0; k < 8; k++) begin
                emit(b[k]);
                if (ones_m == 6) emit(1'b0);
            end
        end
        exp_q.push_back(SE0);
        exp_q.push_back(SE0);
        exp_q.push_back(J);
        nsym += 3;
    endtask

    always @(negedge clk) begin
        cyc_g++;
        if (tx_ready) rdy_t.push_back(cyc_g);
        if (busy) begin
            if (pcyc == 0) t_b = cyc_g;
            if (pcyc % 16 == 8) begin
                if (exp_q.size() == 0) chk("extra_symbol", int'(q), -1);
                else chk($sformatf("sym%0d", pcyc / 16), int'(q), int'(exp_q.pop_front()));
                chk("oe", int'(oe), 1);
            end
            pcyc++;
        end else begin
            if (pcyc != 0) busy_len = pcyc;
            pcyc = 0;
        end
    end

    task automatic wait_busy();
        int i;
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        chk("busy_start", int'(busy), 1);
    endtask

    task automatic feed(input int n);
        for (int k = 0; k < n; k++) begin
            int i;
            for (i = 0; i < 400; i++) begin
                @(negedge clk);
                if (tx_ready) break;
            end
            if (i == 400) begin
                chk("ready_timeout", 0, 1);
                tx_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (k == n - 1) tx_valid = 1'b0;
            else tx_data = pk[k+1];
        end
    endtask

    task automatic finish_pkt(input int n, input string tag);
        int i;
        for (i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        #1;
        chk({tag, "_end"}, int'(busy), 0);
        chk({tag, "_len"}, busy_len, nsym * 16);
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_nrdy"}, rdy_t.size(), n);
        for (int k = 0; k < n && k < rdy_t.size(); k++)
            chk({tag, "_rdy_t"}, rdy_t[k] - t_b, 16 * rdy_exp[k] - 1);
    endtask

    task automatic run(input int n, input string tag);
        @(posedge clk);
        #1;
        model(n);
        tx_data = pk[0];
        tx_valid = 1'b1;
        if (n == 0) begin
            wait_busy();
            repeat (3) @(negedge clk);
            tx_valid = 1'b0;
        end else feed(n);
        finish_pkt(n, tag);
    endtask

    initial begin
        int i;
        reset = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_q", int'(q), int'(J));
        chk("rst_oe", int'(oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rdy", int'(tx_ready), 0);

        pk[0] = 8'h00; run(1, "b00");
        pk[0] = 8'hFF; run(1, "bFF");
        pk[0] = 8'h3F; pk[1] = 8'hFF; run(2, "b3F_FF");
        pk[0] = 8'h80; pk[1] = 8'h1F; run(2, "b80_1F");
        pk[0] = 8'hFE; run(1, "bFE");
        pk[0] = 8'hFC; run(1, "bFC");

        // SYNC-only packet, then tx_valid raised during EOP_J starts the next packet only after IDLE
        @(posedge clk);
        #1;
        model(0);
        tx_data = 8'h00;
        tx_valid = 1'b1;
        wait_busy();
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q == SE0) break;
        end
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q == J) break;
        end
        chk("eopj_seen", int'(q == J && busy), 1);
        tx_valid = 1'b1;
        finish_pkt(0, "sync_only");
        pk[0] = 8'h00;
        model(1);
        @(negedge clk);
        chk("restart", int'(busy), 1);
        feed(1);
        finish_pkt(1, "after_eopj");

        // abort mid-byte with reset
        @(posedge clk);
        #1;
        pk[0] = 8'hFF;
        model(1);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        feed(1);
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_q", int'(q), int'(J));
        chk("abort_oe", int'(oe), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rdy", int'(tx_ready), 0);
        pk[0] = 8'hFF; run(1, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
